decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; reset_n in 1, asynchronous active-low reset.
REQ-002 SHALL have ports: instr_f in 32, fetched instruction; pc_f in 32, fetch PC; valid_f in 1, fetch slot valid.
REQ-003 SHALL have ports: stall_d in 1, external hold; flush_d in 1, kill decode slot (branch/jump taken).
REQ-004 SHALL have ports: instr_d out 32; pc_d out 32; valid_d out 1; rs1_d, rs2_d, rd_d out 5 each.
REQ-005 SHALL have ports: immsrc_d out 3, immediate-format select for the immediate extender; regwrite_d, memwrite_d, alusrc_d, branch_d, jump_d out 1 each; resultsrc_d out 2; illegal_d out 1.
REQ-006 SHALL have port hazard_stall out 1, load-use stall request to fetch.

Function
REQ-007 SHALL register instr_f, pc_f and valid_f into instr_d, pc_d and valid_d on each rising clk edge when advancing.
REQ-008 Advance SHALL mean not stall_d and not hazard_stall; otherwise instr_d, pc_d and valid_d SHALL hold.
REQ-009 flush_d SHALL load instr_d=0x00000013 (NOP) and valid_d=0, and SHALL override both stall_d and hazard_stall.
REQ-010 rs1_d, rs2_d and rd_d SHALL be instr_d[19:15], [24:20] and [11:7] combinationally.
REQ-011 immsrc encoding SHALL be I=000, S=001, B=010, J=011, U=100.
REQ-012 Opcode decode on instr_d[6:0] (immsrc/regwrite/memwrite/alusrc/branch/jump/resultsrc):
 - 0000011 load: 000/1/0/1/0/0/01
 - 0100011 store: 001/0/1/1/0/0/00
 - 0110011 R-type: 000/1/0/0/0/0/00
 - 0010011 I-ALU: 000/1/0/1/0/0/00
 - 1100011 branch: 010/0/0/0/1/0/00
 - 1101111 jal: 011/1/0/0/0/1/10
 - 1100111 jalr: 000/1/0/1/0/1/10
 - 0110111 lui, 0010111 auipc: 100/1/0/1/0/0/00
REQ-013 Any other opcode with valid_d=1 SHALL drive illegal_d=1, immsrc_d=000 and all other controls 0.
REQ-014 regwrite_d, memwrite_d, branch_d, jump_d and illegal_d SHALL be forced to 0 when valid_d=0.
REQ-015 rs1 SHALL count as used for all opcodes except lui, auipc and jal; rs2 SHALL count as used for R-type, store and branch only.
REQ-016 Internal registers ex_load_q and ex_rd_q SHALL capture (load & valid_d) and rd_d at each clk edge.
REQ-017 When hazard_stall=1 or flush_d=1, ex_load_q SHALL instead be loaded with 0 (bubble).
REQ-018 When stall_d=1 and neither hazard_stall nor flush_d is set, ex_load_q and ex_rd_q SHALL hold.
REQ-019 hazard_stall SHALL be combinational: valid_d & ex_load_q & ex_rd_q!=0 & ((rs1 used & rs1_d==ex_rd_q) | (rs2 used & rs2_d==ex_rd_q)).
REQ-020 Latency SHALL be one cycle from instr_f to all decode outputs.

Reset
REQ-021 reset_n=0 SHALL asynchronously set instr_d=0x00000013, pc_d=0, valid_d=0, ex_load_q=0 and ex_rd_q=0.
REQ-022 While in reset, all control outputs and hazard_stall SHALL be 0; assertion mid-stall SHALL discard the held instruction.

Structure
REQ-023 Opcode constants, the immsrc encodings, the resultsrc encodings and the NOP constant SHALL reside in a shared package used by the extender and controller.
REQ-024 Combinational opcode decode SHALL be a sub-module main_decoder; pipeline register and hazard logic SHALL stay in decode_stage.

Verification
REQ-025 Reset: hold reset_n=0 with instr_f=0x00C0006F, valid_f=1 -> instr_d=0x00000013, valid_d=0, hazard_stall=0.
REQ-026 Decode sweep: 0x00052283 (lw), 0x00552023 (sw), 0xFE000EE3 (beq), 0x00C0006F (jal), 0x000153B7 (lui) -> immsrc_d equal to 000, 001, 010, 011, 100 respectively with REQ-012 controls.
REQ-027 Load-use: lw x5,0(x10) followed by add x6,x5,x7 -> hazard_stall=1 for exactly one cycle and the add is held; with rd=x0 -> no stall.
REQ-028 Flush vs stall: stall_d=1 and flush_d=1 in the same cycle -> next cycle instr_d=NOP and valid_d=0.
REQ-029 Illegal: instr 0xFFFFFFFF with valid -> illegal_d=1 and all controls 0; the same instruction with valid_d=0 -> illegal_d=0.
REQ-030 Async reset asserted between clock edges during hazard_stall=1 -> outputs clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg
// Constants and types shared by the decode stage, its main decoder and the
// downstream immediate extender / result mux:
//   - RV32I base opcodes recognised by the decoder
//   - immsrc_e   : immediate-format select (I/S/B/J/U)
//   - resultsrc_e: writeback result select (ALU / memory / PC+4)
//   - NOP_INSTR  : canonical NOP (addi x0,x0,0)
//   - ctrl_t     : bundle of decoded control fields
package decode_stage_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } immsrc_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } resultsrc_e;

  typedef struct packed {
    immsrc_e    immsrc;
    logic       regwrite;
    logic       memwrite;
    logic       alusrc;
    logic       branch;
    logic       jump;
    resultsrc_e resultsrc;
    logic       illegal;
    logic       rs1_used;
    logic       rs2_used;
    logic       is_load;
  } ctrl_t;

endpackage

// File: rtl/decode_stage_main_decoder.sv
// main_decoder
// Purely combinational opcode decoder for the decode stage.
// Ports:
//   opcode in  7       : instr_d[6:0]
//   ctrl   out ctrl_t  : immediate select, datapath controls, illegal flag,
//                        register-usage flags for hazard detection, load flag
// Validity gating is applied by the caller; this block only looks at the opcode.
module main_decoder
  import decode_stage_pkg::*;
(
  input  logic [6:0] opcode,
  output ctrl_t      ctrl
);

  // Table-driven decode. Everything defaults to zero with rs1 counted as
  // read, because only lui/auipc/jal lack an rs1 field; unknown opcodes fall
  // through to the illegal flag with all datapath controls left at zero.
  always_comb begin
    ctrl          = '0;
    ctrl.rs1_used = 1'b1;
    case (opcode)
      OP_LOAD: begin
        ctrl.regwrite  = 1'b1;
        ctrl.alusrc    = 1'b1;
        ctrl.resultsrc = RES_MEM;
        ctrl.is_load   = 1'b1;
      end
      OP_STORE: begin
        ctrl.immsrc   = IMM_S;
        ctrl.memwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.rs2_used = 1'b1;
      end
      OP_RTYPE: begin
        ctrl.regwrite = 1'b1;
        ctrl.rs2_used = 1'b1;
      end
      OP_IALU: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.immsrc   = IMM_B;
        ctrl.branch   = 1'b1;
        ctrl.rs2_used = 1'b1;
      end
      OP_JAL: begin
        ctrl.immsrc    = IMM_J;
        ctrl.regwrite  = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.resultsrc = RES_PC4;
        ctrl.rs1_used  = 1'b0;
      end
      OP_JALR: begin
        ctrl.regwrite  = 1'b1;
        ctrl.alusrc    = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.resultsrc = RES_PC4;
      end
      OP_LUI, OP_AUIPC: begin
        ctrl.immsrc   = IMM_U;
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.rs1_used = 1'b0;
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage
// IF/ID pipeline register, instruction decode and load-use hazard detection.
// Ports:
//   clk, reset_n                 : rising-edge clock, async active-low reset
//   instr_f, pc_f, valid_f       : fetch slot
//   stall_d                      : external hold of the decode slot
//   flush_d                      : kill the decode slot (taken branch/jump)
//   instr_d, pc_d, valid_d       : registered decode slot
//   rs1_d, rs2_d, rd_d           : register fields of instr_d
//   immsrc_d, regwrite_d, memwrite_d, alusrc_d, branch_d, jump_d,
//   resultsrc_d, illegal_d       : decoded controls
//   hazard_stall                 : load-use stall request back to fetch
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr_f,
  input  logic [31:0] pc_f,
  input  logic        valid_f,
  input  logic        stall_d,
  input  logic        flush_d,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic        valid_d,
  output logic [4:0]  rs1_d,
  output logic [4:0]  rs2_d,
  output logic [4:0]  rd_d,
  output logic [2:0]  immsrc_d,
  output logic        regwrite_d,
  output logic        memwrite_d,
  output logic        alusrc_d,
  output logic        branch_d,
  output logic        jump_d,
  output logic [1:0]  resultsrc_d,
  output logic        illegal_d,
  output logic        hazard_stall
);

  ctrl_t      ctrl;
  logic       ex_load_q;
  logic [4:0] ex_rd_q;
  logic       advance;
  logic       rs1_hit;
  logic       rs2_hit;

  main_decoder u_main_decoder (
    .opcode (instr_d[6:0]),
    .ctrl   (ctrl)
  );

  assign rs1_d = instr_d[19:15];
  assign rs2_d = instr_d[24:20];
  assign rd_d  = instr_d[11:7];

  // A load in EX whose destination is read by the decode-slot instruction
  // cannot forward in time; x0 is never a real dependency.
  assign rs1_hit      = ctrl.rs1_used && (rs1_d == ex_rd_q);
  assign rs2_hit      = ctrl.rs2_used && (rs2_d == ex_rd_q);
  assign hazard_stall = valid_d && ex_load_q && (ex_rd_q != 5'd0) && (rs1_hit || rs2_hit);
  assign advance      = !stall_d && !hazard_stall;

  // Decode slot register. Flush wins over any stall so a killed instruction
  // never survives a hold; pc_d is left alone because it is meaningless
  // once the slot is invalid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_d <= NOP_INSTR;
      pc_d    <= 32'd0;
      valid_d <= 1'b0;
    end else if (flush_d) begin
      instr_d <= NOP_INSTR;
      valid_d <= 1'b0;
    end else if (advance) begin
      instr_d <= instr_f;
      pc_d    <= pc_f;
      valid_d <= valid_f;
    end
  end

  // Shadow of the instruction entering EX, just enough to spot a load-use.
  // A hazard or flush sends a bubble into EX, so the load flag is cleared;
  // a plain external stall freezes EX along with decode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_load_q <= 1'b0;
      ex_rd_q   <= 5'd0;
    end else if (hazard_stall || flush_d) begin
      ex_load_q <= 1'b0;
      ex_rd_q   <= rd_d;
    end else if (!stall_d) begin
      ex_load_q <= ctrl.is_load && valid_d;
      ex_rd_q   <= rd_d;
    end
  end

  // Side-effecting controls only fire for a valid slot.
  assign regwrite_d = valid_d && ctrl.regwrite;
  assign memwrite_d = valid_d && ctrl.memwrite;
  assign branch_d   = valid_d && ctrl.branch;
  assign jump_d     = valid_d && ctrl.jump;
  assign illegal_d  = valid_d && ctrl.illegal;

  // Reset parks a NOP in the slot, whose I-format decode would still show
  // alusrc=1, so the datapath selects are also held at zero during reset.
  assign alusrc_d    = reset_n && ctrl.alusrc;
  assign immsrc_d    = reset_n ? ctrl.immsrc : IMM_I;
  assign resultsrc_d = reset_n ? ctrl.resultsrc : RES_ALU;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
// Scoreboard bench for decode_stage: a stimulus process drives the fetch
// slot and controls, predicts each cycle's decode outputs from a reference
// model of the stage and queues them; a monitor compares on every falling edge.
module tb_decode_stage;

  logic        clk;
  logic        reset_n;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic        valid_f;
  logic        stall_d;
  logic        flush_d;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic        valid_d;
  logic [4:0]  rs1_d;
  logic [4:0]  rs2_d;
  logic [4:0]  rd_d;
  logic [2:0]  immsrc_d;
  logic        regwrite_d;
  logic        memwrite_d;
  logic        alusrc_d;
  logic        branch_d;
  logic        jump_d;
  logic [1:0]  resultsrc_d;
  logic        illegal_d;
  logic        hazard_stall;

  decode_stage dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .instr_f      (instr_f),
    .pc_f         (pc_f),
    .valid_f      (valid_f),
    .stall_d      (stall_d),
    .flush_d      (flush_d),
    .instr_d      (instr_d),
    .pc_d         (pc_d),
    .valid_d      (valid_d),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .rd_d         (rd_d),
    .immsrc_d     (immsrc_d),
    .regwrite_d   (regwrite_d),
    .memwrite_d   (memwrite_d),
    .alusrc_d     (alusrc_d),
    .branch_d     (branch_d),
    .jump_d       (jump_d),
    .resultsrc_d  (resultsrc_d),
    .illegal_d    (illegal_d),
    .hazard_stall (hazard_stall)
  );

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [2:0] imm;
    logic       rw;
    logic       mw;
    logic       as;
    logic       br;
    logic       jp;
    logic [1:0] res;
    logic       ill;
    logic       u1;
    logic       u2;
    logic       ld;
  } ref_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pc_known;
    logic        valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  imm;
    logic        rw;
    logic        mw;
    logic        as;
    logic        br;
    logic        jp;
    logic [1:0]  res;
    logic        ill;
    logic        hz;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  // Reference state: what sits in the decode slot, and what the stage most
  // recently handed to execute (only whether it is a valid load and its rd).
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic        m_pc_known;
  logic        m_valid;
  logic        m_ex_load;
  logic [4:0]  m_ex_rd;
  logic        m_in_reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Control table rows: {immsrc, regwrite, memwrite, alusrc, branch, jump, resultsrc}
  function automatic ref_t refDecode(input logic [31:0] ins);
    ref_t       d;
    logic [6:0] op;
    logic [9:0] row;
    d  = '0;
    op = ins[6:0];
    case (op)
      7'b0000011: row = 10'b000_1_0_1_0_0_01;
      7'b0100011: row = 10'b001_0_1_1_0_0_00;
      7'b0110011: row = 10'b000_1_0_0_0_0_00;
      7'b0010011: row = 10'b000_1_0_1_0_0_00;
      7'b1100011: row = 10'b010_0_0_0_1_0_00;
      7'b1101111: row = 10'b011_1_0_0_0_1_10;
      7'b1100111: row = 10'b000_1_0_1_0_1_10;
      7'b0110111: row = 10'b100_1_0_1_0_0_00;
      7'b0010111: row = 10'b100_1_0_1_0_0_00;
      default: begin
        row   = 10'b0;
        d.ill = 1'b1;
      end
    endcase
    {d.imm, d.rw, d.mw, d.as, d.br, d.jp, d.res} = row;
    d.u1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
    d.u2 = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
    d.ld = (op == 7'b0000011);
    return d;
  endfunction

  function automatic void modelReset();
    m_instr    = NOP;
    m_pc       = 32'd0;
    m_pc_known = 1'b1;
    m_valid    = 1'b0;
    m_ex_load  = 1'b0;
    m_ex_rd    = 5'd0;
  endfunction

  function automatic exp_t modelOutputs();
    exp_t e;
    ref_t d;
    d          = refDecode(m_instr);
    e          = '0;
    e.instr    = m_instr;
    e.pc       = m_pc;
    e.pc_known = m_pc_known;
    e.valid    = m_valid;
    e.rs1      = m_instr[19:15];
    e.rs2      = m_instr[24:20];
    e.rd       = m_instr[11:7];
    if (!m_in_reset) begin
      e.imm = d.imm;
      e.as  = d.as;
      e.res = d.res;
      e.rw  = d.rw  && m_valid;
      e.mw  = d.mw  && m_valid;
      e.br  = d.br  && m_valid;
      e.jp  = d.jp  && m_valid;
      e.ill = d.ill && m_valid;
      e.hz  = m_valid && m_ex_load && (m_ex_rd != 5'd0) &&
              ((d.u1 && e.rs1 == m_ex_rd) || (d.u2 && e.rs2 == m_ex_rd));
    end
    return e;
  endfunction

  // Advance the reference by one clock edge given the inputs seen at it.
  function automatic void modelStep(input logic [31:0] ins, input logic [31:0] pc,
                                    input logic v, input logic st, input logic fl,
                                    input logic hz);
    ref_t d;
    d = refDecode(m_instr);
    if (fl || hz) begin
      m_ex_load = 1'b0;
    end else if (!st) begin
      m_ex_load = m_valid && d.ld;
      m_ex_rd   = m_instr[11:7];
    end
    if (fl) begin
      m_instr    = NOP;
      m_valid    = 1'b0;
      m_pc_known = 1'b0;
    end else if (!st && !hz) begin
      m_instr    = ins;
      m_pc       = pc;
      m_pc_known = 1'b1;
      m_valid    = v;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s @%0t: got %h, expected %h", name, $time, act, expv);
    end
  endtask

  // One cycle: optional synchronous-looking reset level, queue the expected
  // outputs for the state now visible, then drive the inputs for the next edge.
  task automatic applyStimulus(input logic rst, input logic [31:0] ins, input logic [31:0] pc,
                               input logic v, input logic st, input logic fl);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n = rst;
    if (!rst) modelReset();
    m_in_reset = !rst;
    e = modelOutputs();
    exp_q.push_back(e);
    instr_f = ins;
    pc_f    = pc;
    valid_f = v;
    stall_d = st;
    flush_d = fl;
    if (rst) modelStep(ins, pc, v, st, fl, e.hz);
  endtask

  // Drop reset between edges while a load-use stall is showing; the slot
  // must clear without waiting for the next clock.
  task automatic asyncResetDuringHazard();
    @(posedge clk);
    #1;
    checkOutput("async_pre_hazard", {31'd0, hazard_stall}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_instr_d", instr_d, NOP);
    checkOutput("async_valid_d", {31'd0, valid_d}, 32'd0);
    checkOutput("async_hazard", {31'd0, hazard_stall}, 32'd0);
    checkOutput("async_regwrite", {31'd0, regwrite_d}, 32'd0);
    modelReset();
    m_in_reset = 1'b1;
    exp_q.push_back(modelOutputs());
  endtask

  function automatic logic [31:0] randInstr();
    logic [31:0] r;
    logic [6:0]  op;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [4:0]  c;
    r = $urandom();
    a = 5'($urandom_range(0, 3));
    b = 5'($urandom_range(0, 3));
    c = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 9))
      0: op = 7'b0000011;
      1: op = 7'b0100011;
      2: op = 7'b0110011;
      3: op = 7'b0010011;
      4: op = 7'b1100011;
      5: op = 7'b1101111;
      6: op = 7'b1100111;
      7: op = 7'b0110111;
      8: op = 7'b0010111;
      default: op = r[7] ? 7'b1111111 : 7'b0001111;
    endcase
    return {r[31:25], b, a, r[14:12], c, op};
  endfunction

  // Monitor: every falling edge, compare the DUT against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("instr_d", instr_d, e.instr);
        if (e.pc_known) checkOutput("pc_d", pc_d, e.pc);
        checkOutput("valid_d", {31'd0, valid_d}, {31'd0, e.valid});
        checkOutput("rs1_d", {27'd0, rs1_d}, {27'd0, e.rs1});
        checkOutput("rs2_d", {27'd0, rs2_d}, {27'd0, e.rs2});
        checkOutput("rd_d", {27'd0, rd_d}, {27'd0, e.rd});
        checkOutput("immsrc_d", {29'd0, immsrc_d}, {29'd0, e.imm});
        checkOutput("regwrite_d", {31'd0, regwrite_d}, {31'd0, e.rw});
        checkOutput("memwrite_d", {31'd0, memwrite_d}, {31'd0, e.mw});
        checkOutput("alusrc_d", {31'd0, alusrc_d}, {31'd0, e.as});
        checkOutput("branch_d", {31'd0, branch_d}, {31'd0, e.br});
        checkOutput("jump_d", {31'd0, jump_d}, {31'd0, e.jp});
        checkOutput("resultsrc_d", {30'd0, resultsrc_d}, {30'd0, e.res});
        checkOutput("illegal_d", {31'd0, illegal_d}, {31'd0, e.ill});
        checkOutput("hazard_stall", {31'd0, hazard_stall}, {31'd0, e.hz});
      end
    end
  end

  initial begin
    reset_n    = 1'b0;
    instr_f    = 32'h00C0006F;
    pc_f       = 32'd0;
    valid_f    = 1'b1;
    stall_d    = 1'b0;
    flush_d    = 1'b0;
    m_in_reset = 1'b1;
    modelReset();

    $display("[TB] reset hold with a valid jal on the fetch side");
    repeat (3) applyStimulus(1'b0, 32'h00C0006F, 32'h100, 1'b1, 1'b0, 1'b0);

    $display("[TB] decode sweep");
    applyStimulus(1'b1, NOP,          32'h1000, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00052283, 32'h1004, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, NOP,          32'h1008, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00552023, 32'h100C, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hFE000EE3, 32'h1010, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00C0006F, 32'h1014, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h000153B7, 32'h1018, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, NOP,          32'h101C, 1'b1, 1'b0, 1'b0);

    $display("[TB] load-use: lw x5 then add x6,x5,x7, then the rd=x0 variant");
    applyStimulus(1'b1, 32'h00052283, 32'h2000, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00728333, 32'h2004, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, NOP,          32'h2008, 1'b1, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b1, NOP, 32'h200C, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00052003, 32'h2010, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00700333, 32'h2014, 1'b1, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b1, NOP, 32'h2018, 1'b1, 1'b0, 1'b0);

    $display("[TB] flush together with stall");
    applyStimulus(1'b1, 32'h00728333, 32'h3000, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00C0006F, 32'h3004, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, NOP,          32'h3008, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, NOP,          32'h300C, 1'b1, 1'b0, 1'b0);

    $display("[TB] illegal opcode, valid then invalid");
    applyStimulus(1'b1, 32'hFFFFFFFF, 32'h4000, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hFFFFFFFF, 32'h4004, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, NOP,          32'h4008, 1'b1, 1'b0, 1'b0);

    $display("[TB] reset during an external stall");
    applyStimulus(1'b1, 32'h00C0006F, 32'h5000, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, NOP,          32'h5004, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, NOP,          32'h5004, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, NOP,          32'h5004, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, NOP,          32'h5008, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, NOP,          32'h500C, 1'b1, 1'b0, 1'b0);

    $display("[TB] asynchronous reset while hazard_stall is high");
    repeat (2) applyStimulus(1'b1, NOP, 32'h6000, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00052283, 32'h6004, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00728333, 32'h6008, 1'b1, 1'b0, 1'b0);
    asyncResetDuringHazard();
    applyStimulus(1'b0, NOP, 32'h600C, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, NOP, 32'h6010, 1'b1, 1'b0, 1'b0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 49) != 0),
                    randInstr(),
                    $urandom(),
                    ($urandom_range(0, 4) != 0),
                    ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 9) == 0));
    end
    applyStimulus(1'b1, NOP, 32'h7000, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    checkOutput("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
